// File: rtl/alu_issue_queue_if.sv
`default_nettype none
// ============================================================================
// alu_issue_queue_if : insert / wakeup / issue bus of the ALU issue queue
// Rev 1.0
// ============================================================================
interface alu_issue_queue_if #(
  parameter int DEPTH     = 8,
  parameter int PREG_W    = 6,
  parameter int ALID_W    = 5,
  parameter int PAYLOAD_W = 64
);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic                        i_flush;
  logic [1:0]                  i_ins_valid;
  logic [1:0][PREG_W-1:0]      i_ins_rs;
  logic [1:0][PREG_W-1:0]      i_ins_rt;
  logic [1:0]                  i_ins_rs_rdy;
  logic [1:0]                  i_ins_rt_rdy;
  logic [1:0][ALID_W-1:0]      i_ins_alid;
  logic [1:0][PAYLOAD_W-1:0]   i_ins_payload;
  logic                        o_ins_stall;
  logic [1:0]                  i_wb_valid;
  logic [1:0][PREG_W-1:0]      i_wb_tag;
  logic                        o_iss_valid;
  logic                        i_iss_ready;
  logic [PREG_W-1:0]           o_iss_rs;
  logic [PREG_W-1:0]           o_iss_rt;
  logic [ALID_W-1:0]           o_iss_alid;
  logic [PAYLOAD_W-1:0]        o_iss_payload;
  logic [c_CNT_W-1:0]          o_count;

  modport slave (
    input  i_flush, i_ins_valid, i_ins_rs, i_ins_rt, i_ins_rs_rdy, i_ins_rt_rdy,
           i_ins_alid, i_ins_payload, i_wb_valid, i_wb_tag, i_iss_ready,
    output o_ins_stall, o_iss_valid, o_iss_rs, o_iss_rt, o_iss_alid,
           o_iss_payload, o_count
  );

  modport master (
    output i_flush, i_ins_valid, i_ins_rs, i_ins_rt, i_ins_rs_rdy, i_ins_rt_rdy,
           i_ins_alid, i_ins_payload, i_wb_valid, i_wb_tag, i_iss_ready,
    input  o_ins_stall, o_iss_valid, o_iss_rs, o_iss_rt, o_iss_alid,
           o_iss_payload, o_count
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// alu_issue_queue : age-ordered collapsing issue queue, oldest-ready select
// Rev 1.0
// ============================================================================
module alu_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int PREG_W    = 6,
  parameter int ALID_W    = 5,
  parameter int PAYLOAD_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_queue_if.slave  bus
);
  localparam int                 c_IDX_W = $clog2(DEPTH);
  localparam int                 c_CNT_W = c_IDX_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

  logic [DEPTH-1:0]     r_valid, r_rs_rdy, r_rt_rdy;
  logic [PREG_W-1:0]    r_rs [DEPTH];
  logic [PREG_W-1:0]    r_rt [DEPTH];
  logic [ALID_W-1:0]    r_alid [DEPTH];
  logic [PAYLOAD_W-1:0] r_payload [DEPTH];
  logic [c_CNT_W-1:0]   r_count;

  logic [DEPTH-1:0]     w_nxt_valid, w_nxt_rs_rdy, w_nxt_rt_rdy, w_shift;
  logic [PREG_W-1:0]    w_nxt_rs [DEPTH];
  logic [PREG_W-1:0]    w_nxt_rt [DEPTH];
  logic [ALID_W-1:0]    w_nxt_alid [DEPTH];
  logic [PAYLOAD_W-1:0] w_nxt_payload [DEPTH];
  logic [c_CNT_W-1:0]   w_nxt_count, w_ins_cnt, w_free, w_base, w_pos0, w_pos1;
  logic                 w_sel_found, w_issue, w_stall, w_do_ins;
  logic [c_IDX_W-1:0]   w_sel_idx;

  function automatic logic f_wb_hit(input logic [PREG_W-1:0] tag,
                                    input logic [1:0] vld,
                                    input logic [1:0][PREG_W-1:0] tags);
    return (vld[0] && (tags[0] == tag)) || (vld[1] && (tags[1] == tag));
  endfunction

  // Descending scan: the last hit written is the lowest (oldest) index.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && r_rs_rdy[i] && r_rt_rdy[i]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = c_IDX_W'(i);
      end
    end
  end

  assign bus.o_iss_valid   = w_sel_found;
  assign bus.o_iss_rs      = r_rs[w_sel_idx];
  assign bus.o_iss_rt      = r_rt[w_sel_idx];
  assign bus.o_iss_alid    = r_alid[w_sel_idx];
  assign bus.o_iss_payload = r_payload[w_sel_idx];
  assign bus.o_count       = r_count;

  assign w_ins_cnt = c_CNT_W'(bus.i_ins_valid[0]) + c_CNT_W'(bus.i_ins_valid[1]);
  assign w_free    = c_DEPTH - r_count;
  assign w_stall   = (w_free < w_ins_cnt);
  assign bus.o_ins_stall = w_stall;

  assign w_issue  = w_sel_found & bus.i_iss_ready;
  assign w_do_ins = ~w_stall & ~bus.i_flush;
  assign w_base   = r_count - c_CNT_W'(w_issue);
  assign w_pos0   = w_base;
  assign w_pos1   = w_base + c_CNT_W'(bus.i_ins_valid[0]);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_shift[i] = w_issue && (c_IDX_W'(i) >= w_sel_idx);
    end
  end

  // Compact over the issued slot, wake up the survivors, then append inserts.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt_valid[i]   = r_valid[i];
      w_nxt_rs_rdy[i]  = r_rs_rdy[i];
      w_nxt_rt_rdy[i]  = r_rt_rdy[i];
      w_nxt_rs[i]      = r_rs[i];
      w_nxt_rt[i]      = r_rt[i];
      w_nxt_alid[i]    = r_alid[i];
      w_nxt_payload[i] = r_payload[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (w_shift[i]) begin
        w_nxt_valid[i]   = r_valid[i+1];
        w_nxt_rs_rdy[i]  = r_rs_rdy[i+1];
        w_nxt_rt_rdy[i]  = r_rt_rdy[i+1];
        w_nxt_rs[i]      = r_rs[i+1];
        w_nxt_rt[i]      = r_rt[i+1];
        w_nxt_alid[i]    = r_alid[i+1];
        w_nxt_payload[i] = r_payload[i+1];
      end
    end
    if (w_shift[DEPTH-1]) begin
      w_nxt_valid[DEPTH-1] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt_rs_rdy[i] = w_nxt_rs_rdy[i] | f_wb_hit(w_nxt_rs[i], bus.i_wb_valid, bus.i_wb_tag);
      w_nxt_rt_rdy[i] = w_nxt_rt_rdy[i] | f_wb_hit(w_nxt_rt[i], bus.i_wb_valid, bus.i_wb_tag);
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (w_do_ins && bus.i_ins_valid[s] &&
            (c_CNT_W'(i) == ((s == 0) ? w_pos0 : w_pos1))) begin
          w_nxt_valid[i]   = 1'b1;
          w_nxt_rs[i]      = bus.i_ins_rs[s];
          w_nxt_rt[i]      = bus.i_ins_rt[s];
          w_nxt_rs_rdy[i]  = bus.i_ins_rs_rdy[s] |
                             f_wb_hit(bus.i_ins_rs[s], bus.i_wb_valid, bus.i_wb_tag);
          w_nxt_rt_rdy[i]  = bus.i_ins_rt_rdy[s] |
                             f_wb_hit(bus.i_ins_rt[s], bus.i_wb_valid, bus.i_wb_tag);
          w_nxt_alid[i]    = bus.i_ins_alid[s];
          w_nxt_payload[i] = bus.i_ins_payload[s];
        end
      end
    end
    w_nxt_count = w_base + (w_do_ins ? w_ins_cnt : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= '0;
      r_rs_rdy <= '0;
      r_rt_rdy <= '0;
      r_count  <= '0;
    end else begin
      r_rs_rdy <= w_nxt_rs_rdy;
      r_rt_rdy <= w_nxt_rt_rdy;
      if (bus.i_flush) begin
        r_valid <= '0;
        r_count <= '0;
      end else begin
        r_valid <= w_nxt_valid;
        r_count <= w_nxt_count;
      end
    end
  end

  // Tag and payload fields are qualified by r_valid and need no reset.
  always_ff @(posedge clk) begin
    r_rs      <= w_nxt_rs;
    r_rt      <= w_nxt_rt;
    r_alid    <= w_nxt_alid;
    r_payload <= w_nxt_payload;
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst) r_count <= c_DEPTH);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// ============================================================================
// tb_alu_issue_queue : directed self-checking bench for alu_issue_queue
// Rev 1.0
// ============================================================================
module tb_alu_issue_queue;
  localparam int DEPTH = 8, PREG_W = 6, ALID_W = 5, PAYLOAD_W = 64;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_issue_queue_if #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ALID_W(ALID_W),
                       .PAYLOAD_W(PAYLOAD_W)) bus ();

  alu_issue_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ALID_W(ALID_W),
                    .PAYLOAD_W(PAYLOAD_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [63:0] f_pay(input logic [4:0] alid);
    return 64'hA5A5_0000_0000_0000 | (64'(alid) * 64'h0001_0001);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_flush       = 1'b0;
    bus.i_ins_valid   = 2'b00;
    bus.i_ins_rs      = '0;
    bus.i_ins_rt      = '0;
    bus.i_ins_rs_rdy  = 2'b00;
    bus.i_ins_rt_rdy  = 2'b00;
    bus.i_ins_alid    = '0;
    bus.i_ins_payload = '0;
    bus.i_wb_valid    = 2'b00;
    bus.i_wb_tag      = '0;
  endtask

  task automatic set_slot(input int s, input logic [5:0] rs, input logic rsr,
                          input logic [5:0] rt, input logic rtr, input logic [4:0] alid);
    bus.i_ins_valid[s]   = 1'b1;
    bus.i_ins_rs[s]      = rs;
    bus.i_ins_rs_rdy[s]  = rsr;
    bus.i_ins_rt[s]      = rt;
    bus.i_ins_rt_rdy[s]  = rtr;
    bus.i_ins_alid[s]    = alid;
    bus.i_ins_payload[s] = f_pay(alid);
  endtask

  task automatic issue_one();
    bus.i_iss_ready = 1'b1;
    step();
    bus.i_iss_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.o_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.o_count); end
    checks++; if (bus.o_iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid: got %b expected 0", bus.o_iss_valid); end
    checks++; if (bus.o_ins_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.o_ins_stall); end
    #3 rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    set_slot(0, 6'd3, 1'b1, 6'd4, 1'b1, 5'd1);
    step(); idle(); #1;
    checks++; if (bus.o_iss_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", bus.o_iss_valid); end
    checks++; if (bus.o_iss_alid !== 5'd1) begin errors++; $display("FAIL basic_alid: got %0d expected 1", bus.o_iss_alid); end
    checks++; if (bus.o_iss_rs !== 6'd3 || bus.o_iss_rt !== 6'd4) begin errors++; $display("FAIL basic_tags: got rs=%0d rt=%0d expected rs=3 rt=4", bus.o_iss_rs, bus.o_iss_rt); end
    checks++; if (bus.o_iss_payload !== f_pay(5'd1)) begin errors++; $display("FAIL basic_payload: got %h expected %h", bus.o_iss_payload, f_pay(5'd1)); end
    checks++; if (bus.o_count !== 4'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", bus.o_count); end
    issue_one();
    checks++; if (bus.o_count !== 4'd0) begin errors++; $display("FAIL basic_drain_count: got %0d expected 0", bus.o_count); end
    checks++; if (bus.o_iss_valid !== 1'b0) begin errors++; $display("FAIL basic_drain_valid: got %b expected 0", bus.o_iss_valid); end
  endtask

  task automatic test_oldest_ready_first();
    set_slot(0, 6'd9, 1'b0, 6'd10, 1'b1, 5'd2);
    set_slot(1, 6'd11, 1'b1, 6'd12, 1'b1, 5'd3);
    step(); idle(); #1;
    checks++; if (bus.o_iss_valid !== 1'b1 || bus.o_iss_alid !== 5'd3) begin errors++; $display("FAIL ooo_first: got valid=%b alid=%0d expected valid=1 alid=3", bus.o_iss_valid, bus.o_iss_alid); end
    checks++; if (bus.o_count !== 4'd2) begin errors++; $display("FAIL ooo_count: got %0d expected 2", bus.o_count); end
    issue_one();
    checks++; if (bus.o_iss_valid !== 1'b0 || bus.o_count !== 4'd1) begin errors++; $display("FAIL ooo_waiting: got valid=%b count=%0d expected valid=0 count=1", bus.o_iss_valid, bus.o_count); end
    bus.i_wb_valid = 2'b01;
    bus.i_wb_tag[0] = 6'd9;
    #1;
    checks++; if (bus.o_iss_valid !== 1'b0) begin errors++; $display("FAIL ooo_no_bypass: got %b expected 0", bus.o_iss_valid); end
    step(); idle(); #1;
    checks++; if (bus.o_iss_valid !== 1'b1 || bus.o_iss_alid !== 5'd2 || bus.o_iss_rs !== 6'd9) begin errors++; $display("FAIL ooo_wakeup: got valid=%b alid=%0d rs=%0d expected valid=1 alid=2 rs=9", bus.o_iss_valid, bus.o_iss_alid, bus.o_iss_rs); end
    issue_one();
    checks++; if (bus.o_count !== 4'd0) begin errors++; $display("FAIL ooo_drain: got %0d expected 0", bus.o_count); end
  endtask

  task automatic test_same_cycle_wakeup();
    set_slot(0, 6'd13, 1'b1, 6'd12, 1'b0, 5'd4);
    bus.i_wb_valid  = 2'b10;
    bus.i_wb_tag[1] = 6'd12;
    step(); idle(); #1;
    checks++; if (bus.o_iss_valid !== 1'b1 || bus.o_iss_alid !== 5'd4) begin errors++; $display("FAIL insert_wakeup: got valid=%b alid=%0d expected valid=1 alid=4", bus.o_iss_valid, bus.o_iss_alid); end
    issue_one();
    set_slot(0, 6'd0, 1'b0, 6'd14, 1'b1, 5'd7);
    step(); idle(); #1;
    checks++; if (bus.o_iss_valid !== 1'b0) begin errors++; $display("FAIL tag0_not_ready: got %b expected 0", bus.o_iss_valid); end
    bus.i_wb_valid  = 2'b01;
    bus.i_wb_tag[0] = 6'd0;
    step(); idle(); #1;
    checks++; if (bus.o_iss_valid !== 1'b1 || bus.o_iss_alid !== 5'd7) begin errors++; $display("FAIL tag0_wakeup: got valid=%b alid=%0d expected valid=1 alid=7", bus.o_iss_valid, bus.o_iss_alid); end
    issue_one();
    checks++; if (bus.o_count !== 4'd0) begin errors++; $display("FAIL tag0_drain: got %0d expected 0", bus.o_count); end
  endtask

  task automatic test_full_stall();
    set_slot(0, 6'd21, 1'b0, 6'd22, 1'b1, 5'd8);
    set_slot(1, 6'd20, 1'b0, 6'd22, 1'b1, 5'd9);
    step(); idle();
    for (int k = 0; k < 3; k++) begin
      set_slot(0, 6'd20, 1'b0, 6'd22, 1'b1, 5'(10 + 2 * k));
      set_slot(1, 6'd20, 1'b0, 6'd22, 1'b1, 5'(11 + 2 * k));
      step(); idle();
    end
    #1;
    checks++; if (bus.o_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", bus.o_count); end
    checks++; if (bus.o_ins_stall !== 1'b0) begin errors++; $display("FAIL full_idle_stall: got %b expected 0", bus.o_ins_stall); end
    set_slot(0, 6'd30, 1'b1, 6'd30, 1'b1, 5'd16);
    #1;
    checks++; if (bus.o_ins_stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b expected 1", bus.o_ins_stall); end
    step(); idle(); #1;
    checks++; if (bus.o_count !== 4'd8 || bus.o_iss_valid !== 1'b0) begin errors++; $display("FAIL full_no_write: got count=%0d valid=%b expected count=8 valid=0", bus.o_count, bus.o_iss_valid); end
    bus.i_wb_valid  = 2'b01;
    bus.i_wb_tag[0] = 6'd21;
    step(); idle(); #1;
    checks++; if (bus.o_iss_valid !== 1'b1 || bus.o_iss_alid !== 5'd8) begin errors++; $display("FAIL full_head_ready: got valid=%b alid=%0d expected valid=1 alid=8", bus.o_iss_valid, bus.o_iss_alid); end
    issue_one();
    checks++; if (bus.o_count !== 4'd7) begin errors++; $display("FAIL full_count7: got %0d expected 7", bus.o_count); end
    set_slot(0, 6'd30, 1'b1, 6'd30, 1'b1, 5'd16);
    set_slot(1, 6'd31, 1'b1, 6'd31, 1'b1, 5'd17);
    #1;
    checks++; if (bus.o_ins_stall !== 1'b1) begin errors++; $display("FAIL count7_two_stall: got %b expected 1", bus.o_ins_stall); end
    bus.i_ins_valid = 2'b01;
    #1;
    checks++; if (bus.o_ins_stall !== 1'b0) begin errors++; $display("FAIL count7_one_stall: got %b expected 0", bus.o_ins_stall); end
    step(); idle(); #1;
    checks++; if (bus.o_count !== 4'd8 || bus.o_iss_alid !== 5'd16 || bus.o_iss_valid !== 1'b1) begin errors++; $display("FAIL count7_accept: got count=%0d valid=%b alid=%0d expected count=8 valid=1 alid=16", bus.o_count, bus.o_iss_valid, bus.o_iss_alid); end
    bus.i_flush = 1'b1;
    step(); idle(); #1;
    checks++; if (bus.o_count !== 4'd0) begin errors++; $display("FAIL full_flush: got %0d expected 0", bus.o_count); end
  endtask

  task automatic test_hold();
    set_slot(0, 6'd1, 1'b1, 6'd2, 1'b1, 5'd5);
    set_slot(1, 6'd3, 1'b1, 6'd4, 1'b1, 5'd6);
    step(); idle();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.o_iss_valid !== 1'b1 || bus.o_iss_alid !== 5'd5) begin errors++; $display("FAIL hold_cycle%0d: got valid=%b alid=%0d expected valid=1 alid=5", k, bus.o_iss_valid, bus.o_iss_alid); end
      step();
    end
    bus.i_iss_ready = 1'b1;
    #1;
    checks++; if (bus.o_iss_alid !== 5'd5) begin errors++; $display("FAIL hold_release_first: got %0d expected 5", bus.o_iss_alid); end
    step(); #1;
    checks++; if (bus.o_iss_valid !== 1'b1 || bus.o_iss_alid !== 5'd6) begin errors++; $display("FAIL hold_release_second: got valid=%b alid=%0d expected valid=1 alid=6", bus.o_iss_valid, bus.o_iss_alid); end
    step();
    bus.i_iss_ready = 1'b0;
    #1;
    checks++; if (bus.o_count !== 4'd0 || bus.o_iss_valid !== 1'b0) begin errors++; $display("FAIL hold_drain: got count=%0d valid=%b expected count=0 valid=0", bus.o_count, bus.o_iss_valid); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 2; k++) begin
      set_slot(0, 6'd40, 1'b0, 6'd41, 1'b1, 5'(20 + 2 * k));
      set_slot(1, 6'd40, 1'b0, 6'd41, 1'b1, 5'(21 + 2 * k));
      step(); idle();
    end
    set_slot(0, 6'd40, 1'b0, 6'd41, 1'b1, 5'd24);
    step(); idle(); #1;
    checks++; if (bus.o_count !== 4'd5) begin errors++; $display("FAIL flush_pre_count: got %0d expected 5", bus.o_count); end
    set_slot(0, 6'd42, 1'b1, 6'd42, 1'b1, 5'd25);
    set_slot(1, 6'd43, 1'b1, 6'd43, 1'b1, 5'd26);
    bus.i_flush = 1'b1;
    step(); idle(); #1;
    checks++; if (bus.o_count !== 4'd0 || bus.o_iss_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got count=%0d valid=%b expected count=0 valid=0", bus.o_count, bus.o_iss_valid); end
    step(); #1;
    checks++; if (bus.o_count !== 4'd0 || bus.o_iss_valid !== 1'b0) begin errors++; $display("FAIL flush_settled: got count=%0d valid=%b expected count=0 valid=0", bus.o_count, bus.o_iss_valid); end
  endtask

  task automatic test_async_reset();
    set_slot(0, 6'd1, 1'b1, 6'd1, 1'b1, 5'd27);
    set_slot(1, 6'd2, 1'b1, 6'd2, 1'b1, 5'd28);
    step(); idle(); #1;
    checks++; if (bus.o_count !== 4'd2 || bus.o_iss_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got count=%0d valid=%b expected count=2 valid=1", bus.o_count, bus.o_iss_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.o_count !== 4'd0 || bus.o_iss_valid !== 1'b0) begin errors++; $display("FAIL areset_immediate: got count=%0d valid=%b expected count=0 valid=0", bus.o_count, bus.o_iss_valid); end
    #1 rst = 1'b0;
    step(); #1;
    checks++; if (bus.o_count !== 4'd0 || bus.o_iss_valid !== 1'b0) begin errors++; $display("FAIL areset_after: got count=%0d valid=%b expected count=0 valid=0", bus.o_count, bus.o_iss_valid); end
  endtask

  initial begin
    idle();
    bus.i_iss_ready = 1'b0;
    test_reset();
    test_basic();
    test_oldest_ready_first();
    test_same_cycle_wakeup();
    test_full_stall();
    test_hold();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Out-of-order issue queue for ALU/branch ops; sits between the decode-stage two-slot pass-through and the ALU.
- Accepts up to 2 renamed instructions per cycle, in slot order, and tracks source-operand readiness by snooping write-back tag broadcasts.
- Issues the oldest fully-ready entry, one per cycle, through a valid/ready handshake.

Parameters:
DEPTH, 8, number of entries (power of two, >= 4)
PREG_W, 6, physical register tag width
ALID_W, 5, active list id width
PAYLOAD_W, 64, opaque per-instruction payload (alu_ctl, immediate, uses_*, branch fields), passed through unmodified

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_flush  in  1  mispredict flush; synchronous clear of all entries
i_ins_valid  in  2  per-slot insert request; slot 0 is older than slot 1
i_ins_rs  in  2xPREG_W  per-slot source rs tag
i_ins_rt  in  2xPREG_W  per-slot source rt tag
i_ins_rs_rdy  in  2  rs already valid (or unused)
i_ins_rt_rdy  in  2  rt already valid (or unused)
i_ins_alid  in  2xALID_W  active list id
i_ins_payload  in  2xPAYLOAD_W  opaque payload
o_ins_stall  out  1  insert refused this cycle; decode must hold both slots
i_wb_valid  in  2  write-back broadcast valid (port 0 ALU, port 1 load)
i_wb_tag  in  2xPREG_W  broadcast physical destination tags
o_iss_valid  out  1  an entry is ready to issue
i_iss_ready  in  1  ALU accepts
o_iss_rs, o_iss_rt  out  PREG_W each  issued source tags
o_iss_alid  out  ALID_W  issued active list id
o_iss_payload  out  PAYLOAD_W  issued payload
o_count  out  clog2(DEPTH)+1  occupied entries (registered)

Behaviour:
- Storage: collapsing queue ordered by age; index 0 is the oldest. Each entry holds valid, rs, rt, rs_rdy, rt_rdy, alid, payload.
- Reset (async, rst=1): all valid bits cleared, o_count=0, o_iss_valid=0, o_ins_stall=0. Payload/tag fields are don't-care.
- Stall: o_ins_stall = (DEPTH - o_count) < popcount(i_ins_valid).
  - Combinational from the registered count; does not credit a same-cycle issue (conservative).
  - All-or-nothing: when stalled, neither slot is written.
- Insert (not stalled, not flushed): valid slots are appended after the current youngest entry, after compaction for any issue that cycle.
  - Slot 0 goes before slot 1. If only slot 1 is valid, it takes the first free position.
- Wakeup: each valid entry sets rs_rdy when rs == any valid i_wb_tag, and likewise rt_rdy. Readiness is registered, so eligibility starts the next cycle.
  - Inserting instructions are also compared against the same-cycle broadcast; a match stores rdy=1 (no lost wakeup).
- Select: the lowest-index entry with valid & rs_rdy & rt_rdy.
  - o_iss_valid and the o_iss_* fields are combinational from registered state only (no wakeup-to-issue bypass).
- Issue handshake: the entry is removed on o_iss_valid & i_iss_ready. Entries above it shift down one index in the same edge.
  - If i_iss_ready=0, state is held and o_iss_* stay stable unless an older entry becomes ready in the next cycle; the selection may change.
- Simultaneous events: issue, insert and wakeup in one cycle are all honoured.
  - Final count = count - issued + inserted.
  - Wakeup applies to the shifted entries.
- Flush: i_flush=1 clears all valid bits at the edge and o_count becomes 0. Flush beats insert and issue that cycle.
  - The issue handshake in a flush cycle still counts as issued to the ALU; the downstream ALU also flushes.
- o_count never exceeds DEPTH and never underflows; an assertion covers both.
- Tag 0 broadcasts are legal and match normally.

Test Plan:
- Reset then insert slot0 {rs=3,rs_rdy=1,rt=4,rt_rdy=1,alid=1} → next cycle o_iss_valid=1, o_iss_alid=1; with i_iss_ready=1, o_count returns to 0.
- Insert A(alid=2, rs=9 not ready) and B(alid=3, all ready) in one cycle → B issues first. Broadcast tag 9 at cycle N → A has o_iss_valid=1 at N+1, not N.
- Insert with rt=12 not ready while i_wb_tag[1]=12 valid in the same cycle → entry issues the following cycle.
- Fill to DEPTH=8; then o_count=8, and i_ins_valid=2'b01 gives o_ins_stall=1 with no write. At count 7, i_ins_valid=2'b11 gives stall=1; 2'b01 is accepted.
- Hold i_iss_ready=0 for 3 cycles with 2 ready entries (alid 5 older, alid 6) → o_iss_alid stays 5; on ready=1, 5 then 6 issue on consecutive cycles.
- Count=5 plus a concurrent insert of 2 and i_flush=1 → count=0 next cycle, o_iss_valid=0. Asserting rst mid-operation clears immediately, without waiting for the clock.
